// File: rtl/demux_1x32_deser_pkg.sv
// Shared types and constants for the 1-to-K serial-to-parallel demux.
package demux_1x32_deser_pkg;

  localparam int K_DEF = 32;

  // FILL: collecting bits; HOLD: presenting a finished frame to the consumer.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/demux_1x32.sv
// Combinational 1-to-K one-hot write-enable decoder.
module demux_1x32 #(
  parameter int K  = 32,
  parameter int SW = $clog2(K)
) (
  input  logic [SW-1:0] idx_i,
  input  logic          en_i,
  output logic [K-1:0]  stb_o
);

  // Raise exactly one strobe at idx_i when enabled; K is a power of two so idx_i is always in range.
  always_comb begin
    stb_o        = '0;
    stb_o[idx_i] = en_i;
  end

endmodule

// File: rtl/demux_1x32_deser.sv
// Serial bit router / deserializer: each accepted bit lands at an auto-incremented
// or explicit index of y; a finished or flushed frame is held until y_ready.
module demux_1x32_deser
  import demux_1x32_deser_pkg::*;
#(
  parameter  int K  = K_DEF,
  localparam int SW = $clog2(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          addr_mode,
  input  logic [SW-1:0] sel,
  input  logic          flush,
  output logic [K-1:0]  y,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [SW:0]   count
);

  localparam logic [SW:0]   CNT_FULL = (SW+1)'(K);
  localparam logic [SW:0]   CNT_LAST = (SW+1)'(K-1);
  localparam logic [SW-1:0] PTR_LAST = SW'(K-1);

  state_e        state_q, state_d;
  logic [K-1:0]  y_q, y_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW:0]   count_q, count_d;

  logic          accept;
  logic [SW-1:0] wr_idx;
  logic [K-1:0]  wr_stb;

  assign accept = din_valid && (state_q == FILL);
  assign wr_idx = addr_mode ? sel : ptr_q;

  demux_1x32 #(.K(K), .SW(SW)) u_dec (
    .idx_i (wr_idx),
    .en_i  (accept),
    .stb_o (wr_stb)
  );

  // State register; reset discards any partial or held frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next state: frame closes on last auto slot, on the K-th bit, or on a non-empty flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if ((accept && ((!addr_mode && ptr_q == PTR_LAST) || count_q == CNT_LAST)) ||
            (flush && (count_q != '0 || accept)))
          state_d = HOLD;
      end
      HOLD: begin
        if (y_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Handshake outputs decoded directly from state.
  always_comb begin
    din_ready = (state_q == FILL);
    y_valid   = (state_q == HOLD);
  end

  // Datapath next values: write on accept, freeze in HOLD, clear when the frame is taken.
  always_comb begin
    y_d     = y_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (state_q == HOLD) begin
      if (y_ready) begin
        y_d     = '0;
        ptr_d   = '0;
        count_d = '0;
      end
    end else begin
      if (accept) begin
        y_d = (y_q & ~wr_stb) | (wr_stb & {K{din}});
        if (count_q != CNT_FULL) count_d = count_q + 1'b1;
        if (!addr_mode)          ptr_d   = ptr_q + 1'b1;
      end
      // Every closed frame restarts the auto pointer at bit 0.
      if (state_d == HOLD) ptr_d = '0;
    end
  end

  // Datapath registers, all reset so no output depends on unreset state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      y_q     <= y_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign y     = y_q;
  assign count = count_q;

endmodule

// File: tb/tb_demux_1x32_deser.sv
// Self-checking bench for demux_1x32_deser: directed scenarios plus randomized frames
// checked against a bit-array model of the frame contents.
module tb_demux_1x32_deser;

  localparam int K = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        din, din_valid, din_ready, addr_mode, flush;
  logic [4:0]  sel;
  logic [31:0] y;
  logic        y_valid, y_ready;
  logic [5:0]  count;

  int checks = 0;
  int errors = 0;

  demux_1x32_deser #(.K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .addr_mode (addr_mode),
    .sel       (sel),
    .flush     (flush),
    .y         (y),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    din_valid = 0; din = 0; flush = 0; y_ready = 0; addr_mode = 0; sel = '0;
  endtask

  task automatic drive(input logic v, input logic b, input logic m,
                       input logic [4:0] s, input logic f);
    din_valid = v; din = b; addr_mode = m; sel = s; flush = f;
    cyc();
    din_valid = 0; flush = 0;
  endtask

  task automatic consume();
    y_ready = 1;
    cyc();
    y_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cyc(); cyc();
    checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y got=%h exp=0", y); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    rst = 0;
    cyc();
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_yvalid got=%b exp=0", y_valid); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_dinready got=%b exp=1", din_ready); end
  endtask

  task automatic test_auto_pattern();
    logic [31:0] pat;
    pat = 32'hA5A5_0F0F;
    for (int i = 0; i < K; i++) begin
      drive(1, pat[i], 0, 5'd0, 0);
      if (i == K-2) begin
        checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL auto_early_valid got=%b exp=0", y_valid); end
      end
    end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL auto_valid got=%b exp=1", y_valid); end
    checks++; if (y !== pat) begin errors++; $display("FAIL auto_y got=%h exp=%h", y, pat); end
    checks++; if (count !== 6'd32) begin errors++; $display("FAIL auto_count got=%0d exp=32", count); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL auto_dinready got=%b exp=0", din_ready); end
    consume();
    checks++; if (y !== 32'h0 || count !== 6'd0 || y_valid !== 1'b0) begin
      errors++; $display("FAIL auto_clear got y=%h cnt=%0d v=%b exp 0/0/0", y, count, y_valid); end
  endtask

  task automatic test_flush_partial();
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 5'd0, 0);
    drive(0, 0, 0, 5'd0, 1);
    checks++; if (y !== 32'h1F) begin errors++; $display("FAIL flush_y got=%h exp=0000001f", y); end
    checks++; if (count !== 6'd5) begin errors++; $display("FAIL flush_count got=%0d exp=5", count); end
    checks++; if (y_valid !== 1'b1) begin errors++; $display("FAIL flush_valid got=%b exp=1", y_valid); end
    consume();
    checks++; if (y !== 32'h0 || count !== 6'd0) begin
      errors++; $display("FAIL flush_clear got y=%h cnt=%0d exp 0/0", y, count); end
  endtask

  task automatic test_explicit();
    drive(1, 1, 1, 5'd31, 0);
    drive(1, 1, 1, 5'd0, 0);
    drive(1, 0, 1, 5'd31, 0);
    checks++; if (y_valid !== 1'b0 || count !== 6'd3) begin
      errors++; $display("FAIL expl_pre got v=%b cnt=%0d exp 0/3", y_valid, count); end
    drive(0, 0, 1, 5'd0, 1);
    checks++; if (y !== 32'h1) begin errors++; $display("FAIL expl_y got=%h exp=00000001", y); end
    checks++; if (count !== 6'd3 || y_valid !== 1'b1) begin
      errors++; $display("FAIL expl_count got cnt=%0d v=%b exp 3/1", count, y_valid); end
    consume();
  endtask

  task automatic test_back_pressure();
    logic [31:0] w;
    w = $urandom;
    for (int i = 0; i < K; i++) drive(1, w[i], 0, 5'd0, 0);
    din_valid = 1;
    for (int c = 0; c < 10; c++) begin
      din = 1'($urandom); addr_mode = 1'($urandom); sel = 5'($urandom); flush = 1'($urandom);
      cyc();
      checks++; if (din_ready !== 1'b0 || y !== w || count !== 6'd32 || y_valid !== 1'b1) begin
        errors++; $display("FAIL hold_stable c=%0d got rdy=%b y=%h cnt=%0d v=%b exp 0/%h/32/1",
                           c, din_ready, y, count, y_valid, w); end
    end
    flush = 0; addr_mode = 0;
    y_ready = 1;
    cyc();
    y_ready = 0; din_valid = 0;
    checks++; if (y_valid !== 1'b0 || din_ready !== 1'b1 || y !== 32'h0 || count !== 6'd0) begin
      errors++; $display("FAIL hold_release got v=%b rdy=%b y=%h cnt=%0d exp 0/1/0/0",
                         y_valid, din_ready, y, count); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 17; i++) drive(1, 1'($urandom), 0, 5'd0, 0);
    #2 rst = 1;
    #1;
    checks++; if (y !== 32'h0 || count !== 6'd0 || y_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async got y=%h cnt=%0d v=%b exp 0/0/0", y, count, y_valid); end
    #2 rst = 0;
    for (int i = 0; i < K; i++) drive(1, 1, 0, 5'd0, 0);
    checks++; if (y !== 32'hFFFF_FFFF || y_valid !== 1'b1 || count !== 6'd32) begin
      errors++; $display("FAIL rst_refill got y=%h v=%b cnt=%0d exp ffffffff/1/32", y, y_valid, count); end
    consume();
  endtask

  task automatic test_flush_empty();
    drive(0, 0, 0, 5'd0, 1);
    checks++; if (y_valid !== 1'b0 || count !== 6'd0 || din_ready !== 1'b1) begin
      errors++; $display("FAIL flush_empty got v=%b cnt=%0d rdy=%b exp 0/0/1", y_valid, count, din_ready); end
    drive(1, 1, 0, 5'd0, 1);
    checks++; if (count !== 6'd1 || y_valid !== 1'b1 || y !== 32'h1) begin
      errors++; $display("FAIL flush_accept got cnt=%0d v=%b y=%h exp 1/1/00000001", count, y_valid, y); end
    consume();
  endtask

  // Random frames: model is the set of written bit positions; frame closes when
  // all K bits arrive or on flush (same-cycle or a following idle cycle).
  task automatic test_random();
    for (int fr = 0; fr < 24; fr++) begin
      logic        mode, late, b, nf;
      logic [4:0]  s;
      logic [31:0] expw;
      int          n, idx, gap;
      mode = 1'($urandom);
      n    = $urandom_range(1, K);
      late = 1'($urandom);
      nf   = (n < K);
      expw = '0;
      for (int j = 0; j < n; j++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++)
          drive(0, 1'($urandom), 1'($urandom), 5'($urandom), (j == 0) ? 1'($urandom) : 1'b0);
        checks++; if (din_ready !== 1'b1 || y_valid !== 1'b0) begin
          errors++; $display("FAIL rnd_fill fr=%0d j=%0d got rdy=%b v=%b exp 1/0", fr, j, din_ready, y_valid); end
        b = 1'($urandom);
        s = 5'($urandom);
        idx = mode ? int'(s) : j;
        expw[idx] = b;
        drive(1, b, mode, s, (j == n-1) && nf && !late);
      end
      if (nf && late) drive(0, 1'($urandom), mode, 5'($urandom), 1);
      checks++; if (y_valid !== 1'b1 || y !== expw || count !== 6'(n)) begin
        errors++; $display("FAIL rnd_frame fr=%0d mode=%b got v=%b y=%h cnt=%0d exp 1/%h/%0d",
                           fr, mode, y_valid, y, count, expw, n); end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        drive(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
      consume();
      checks++; if (y !== 32'h0 || count !== 6'd0 || din_ready !== 1'b1) begin
        errors++; $display("FAIL rnd_clear fr=%0d got y=%h cnt=%0d rdy=%b exp 0/0/1", fr, y, count, din_ready); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_auto_pattern();
    test_flush_partial();
    test_explicit();
    test_back_pressure();
    test_reset_midframe();
    test_flush_empty();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
